// File: rtl/plot_pkg.sv
// plot_pkg: shared state encodings, requester indices and constants for the plot arbiter
package plot_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ACTIVE, RELEASE} state_t;
  localparam int REQ_LOAD  = 0;
  localparam int REQ_BALL  = 1;
  localparam int REQ_BRICK = 2;
  localparam int REQ_PLAT  = 3;
  localparam int HOLD_W    = 20;
  localparam logic [2:0] BLACK = 3'b000;
endpackage

// File: rtl/plot_arbiter_rr_pick.sv
// rr_pick: round-robin find-first of eligible requesters starting at ptr
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
)(
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx,
  output logic [NREQ-1:0] onehot
);
  logic [NREQ-1:0] rot;
  logic [IW-1:0]   ff;
  logic [IW:0]     sum;
  // rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back
  always_comb begin
    rot = NREQ'({eligible, eligible} >> ptr);
    ff  = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) ff = IW'(i);
    sum    = {1'b0, ff} + {1'b0, ptr};
    idx    = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
    any    = |eligible;
    onehot = any ? (NREQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin sharing of the VGA plot port between pixel requesters
module plot_arbiter import plot_pkg::*; #(
  parameter int                NREQ     = 4,
  parameter int                XW       = 10,
  parameter int                YW       = 10,
  parameter int                CW       = 3,
  parameter logic [HOLD_W-1:0] MAX_HOLD = 20'd20000
)(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*XW-1:0]   x_in,
  input  logic [NREQ*YW-1:0]   y_in,
  input  logic [NREQ*CW-1:0]   colour_in,
  input  logic [NREQ-1:0]      wen_in,
  input  logic                 erase,
  input  logic                 err_clr,
  output logic [NREQ-1:0]      grant,
  output logic [XW-1:0]        x,
  output logic [YW-1:0]        y,
  output logic [CW-1:0]        colour,
  output logic                 plot,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d, mask_q, mask_d, pick_oh;
  logic [IW-1:0]     gidx_q, gidx_d, ptr_q, ptr_d, pick_idx;
  logic              erase_lat_q, erase_lat_d, plot_q, plot_d, err_q, err_d, pick_any;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [CW-1:0]     colour_q, colour_d;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .eligible(req & ~mask_q),
    .ptr     (ptr_q),
    .any     (pick_any),
    .idx     (pick_idx),
    .onehot  (pick_oh)
  );

  // next-state and registered plot-port datapath
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    erase_lat_d = erase_lat_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    plot_d      = 1'b0;
    mask_d      = mask_q & req;
    err_d       = err_clr ? 1'b0 : err_q;
    case (state_q)
      IDLE: if (pick_any) begin
        state_d     = GRANT;
        grant_d     = pick_oh;
        gidx_d      = pick_idx;
        erase_lat_d = erase;
      end
      GRANT: begin
        hold_d  = '0;
        state_d = ACTIVE;
      end
      ACTIVE: begin
        x_d      = x_in[gidx_q*XW +: XW];
        y_d      = y_in[gidx_q*YW +: YW];
        colour_d = erase_lat_q ? CW'(BLACK) : colour_in[gidx_q*CW +: CW];
        plot_d   = wen_in[gidx_q];
        hold_d   = hold_q + 1'b1;
        if (!req[gidx_q]) begin
          plot_d  = 1'b0;
          state_d = RELEASE;
        end else if (hold_q == MAX_HOLD - 1'b1) begin
          plot_d         = 1'b0;
          err_d          = 1'b1;
          mask_d[gidx_q] = 1'b1;
          state_d        = RELEASE;
        end
      end
      RELEASE: begin
        grant_d = '0;
        ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers, cleared immediately by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      erase_lat_q <= 1'b0;
      ptr_q       <= '0;
      mask_q      <= '0;
      hold_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
      plot_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      erase_lat_q <= erase_lat_d;
      ptr_q       <= ptr_d;
      mask_q      <= mask_d;
      hold_q      <= hold_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
      plot_q      <= plot_d;
      err_q       <= err_d;
    end
  end

  assign grant       = grant_q;
  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign plot        = plot_q;
  assign busy        = state_q != IDLE;
  assign timeout_err = err_q;
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: directed table and sequence checks of the plot arbiter
module tb_plot_arbiter;
  import plot_pkg::*;
  localparam int NREQ = 4, XW = 10, YW = 10, CW = 3;
  logic clk = 1'b0, resetn = 1'b0, erase = 1'b0, err_clr = 1'b0;
  logic [NREQ-1:0] req = '0, wen_in = '0, grant;
  logic [NREQ*XW-1:0] x_in = '0;
  logic [NREQ*YW-1:0] y_in = '0;
  logic [NREQ*CW-1:0] colour_in = '0;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic plot, busy, timeout_err;
  int checks = 0, failures = 0;

  typedef struct {
    logic [3:0] req, wen;
    logic [9:0] xv;
    logic [2:0] cv;
    logic       er;
    logic [3:0] eg;
    logic       ep;
    logic [9:0] ex;
    logic [2:0] ec;
    logic       eb;
  } vec_t;
  vec_t tv[16];

  always #5 clk = ~clk;

  plot_arbiter #(.NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW), .MAX_HOLD(20'd8)) dut (
    .clk(clk), .resetn(resetn), .req(req), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .wen_in(wen_in), .erase(erase), .err_clr(err_clr),
    .grant(grant), .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int g;
    tv[0]  = '{4'b0010, 4'b0000, 10'd0,  3'd4, 1'b0, 4'b0010, 1'b0, 10'd0,  3'd0, 1'b1};
    tv[1]  = '{4'b0010, 4'b0000, 10'd0,  3'd4, 1'b0, 4'b0010, 1'b0, 10'd0,  3'd0, 1'b1};
    tv[2]  = '{4'b0010, 4'b0010, 10'd10, 3'd4, 1'b0, 4'b0010, 1'b1, 10'd10, 3'd4, 1'b1};
    tv[3]  = '{4'b0010, 4'b0010, 10'd11, 3'd4, 1'b0, 4'b0010, 1'b1, 10'd11, 3'd4, 1'b1};
    tv[4]  = '{4'b0010, 4'b0010, 10'd12, 3'd4, 1'b0, 4'b0010, 1'b1, 10'd12, 3'd4, 1'b1};
    tv[5]  = '{4'b0010, 4'b0010, 10'd13, 3'd4, 1'b0, 4'b0010, 1'b1, 10'd13, 3'd4, 1'b1};
    tv[6]  = '{4'b0010, 4'b0010, 10'd14, 3'd4, 1'b0, 4'b0010, 1'b1, 10'd14, 3'd4, 1'b1};
    tv[7]  = '{4'b0000, 4'b0010, 10'd14, 3'd4, 1'b0, 4'b0010, 1'b0, 10'd14, 3'd4, 1'b1};
    tv[8]  = '{4'b0000, 4'b0000, 10'd14, 3'd4, 1'b0, 4'b0000, 1'b0, 10'd14, 3'd4, 1'b0};
    tv[9]  = '{4'b1000, 4'b0000, 10'd14, 3'd7, 1'b1, 4'b1000, 1'b0, 10'd14, 3'd4, 1'b1};
    tv[10] = '{4'b1000, 4'b0000, 10'd14, 3'd7, 1'b0, 4'b1000, 1'b0, 10'd14, 3'd4, 1'b1};
    tv[11] = '{4'b1000, 4'b1000, 10'd30, 3'd7, 1'b0, 4'b1000, 1'b1, 10'd30, 3'd0, 1'b1};
    tv[12] = '{4'b1000, 4'b1000, 10'd31, 3'd7, 1'b1, 4'b1000, 1'b1, 10'd31, 3'd0, 1'b1};
    tv[13] = '{4'b1000, 4'b1000, 10'd32, 3'd7, 1'b0, 4'b1000, 1'b1, 10'd32, 3'd0, 1'b1};
    tv[14] = '{4'b0000, 4'b1000, 10'd32, 3'd7, 1'b0, 4'b1000, 1'b0, 10'd32, 3'd0, 1'b1};
    tv[15] = '{4'b0000, 4'b0000, 10'd32, 3'd7, 1'b0, 4'b0000, 1'b0, 10'd32, 3'd0, 1'b0};

    x_in = '1; colour_in = '1; wen_in = '1;
    #12;
    chk("rst grant", grant, 0);
    chk("rst plot", plot, 0);
    chk("rst busy", busy, 0);
    chk("rst err", timeout_err, 0);
    chk("rst x", x, 0);
    chk("rst colour", colour, 0);
    resetn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      req = tv[i].req; wen_in = tv[i].wen; erase = tv[i].er;
      x_in = {NREQ{tv[i].xv}}; y_in = {NREQ{10'd20}}; colour_in = {NREQ{tv[i].cv}};
      tick();
      chk($sformatf("v%0d grant", i), grant, tv[i].eg);
      chk($sformatf("v%0d plot", i), plot, tv[i].ep);
      chk($sformatf("v%0d x", i), x, tv[i].ex);
      chk($sformatf("v%0d colour", i), colour, tv[i].ec);
      chk($sformatf("v%0d busy", i), busy, tv[i].eb);
      if (tv[i].ep) chk($sformatf("v%0d y", i), y, 20);
    end

    req = 4'b1111; wen_in = '0; erase = 1'b0;
    for (int n = 0; n < 5; n++) begin
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
        tick();
        chk("rr onehot", $onehot0(grant), 1);
        done = grant != 0;
      end
      chk($sformatf("rr grant %0d", n), grant, 1 << (n % 4));
      g = n % 4;
      tick();
      for (int p = 0; p < 3; p++) begin
        x_in[g*XW +: XW] = 10'(100 + p); wen_in[g] = 1'b1;
        tick();
        chk("rr plot", plot, 1);
        chk("rr x", x, 100 + p);
      end
      wen_in = '0; req[g] = 1'b0;
      tick();
      chk("rr drop plot", plot, 0);
      req[g] = 1'b1;
      tick();
      chk("rr release", grant, 0);
    end

    req = 4'b0101; wen_in = '0;
    tick();
    chk("to grant2", grant, 4'b0100);
    tick();
    wen_in = 4'b0100; err_clr = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("to plot %0d", i), plot, i < 8);
      chk($sformatf("to err %0d", i), timeout_err, i == 8);
    end
    wen_in = '0; err_clr = 1'b0;
    tick();
    chk("to release", grant, 0);
    chk("to err sticky", timeout_err, 1);
    tick();
    chk("to next grant0", grant, 4'b0001);
    tick();
    req = 4'b0100;
    tick();
    tick();
    chk("to rel0", grant, 0);
    tick();
    tick();
    chk("to masked", grant, 0);
    chk("to masked busy", busy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to err_clr", timeout_err, 0);
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    chk("to regrant2", grant, 4'b0100);
    req = 4'b0000;
    tick(); tick(); tick();
    chk("to idle", busy, 0);

    req = 4'b0010;
    tick();
    chk("bd grant", grant, 4'b0010);
    tick();
    wen_in = 4'b0010;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("bd plot %0d", i), plot, 1);
    end
    req = 4'b0000;
    tick();
    chk("bd drop plot", plot, 0);
    chk("bd err", timeout_err, 0);
    req = 4'b0010; wen_in = '0;
    tick();
    chk("bd release", grant, 0);
    tick();
    chk("bd no mask", grant, 4'b0010);
    chk("bd err2", timeout_err, 0);
    req = 4'b0000;
    tick(); tick(); tick();
    chk("bd idle", busy, 0);

    req = 4'b1000;
    tick();
    chk("rs grant", grant, 4'b1000);
    tick();
    wen_in = 4'b1000; x_in[3*XW +: XW] = 10'd77;
    tick();
    chk("rs plot", plot, 1);
    chk("rs x", x, 77);
    #2 resetn = 1'b0;
    #1;
    chk("rs plot async", plot, 0);
    chk("rs grant async", grant, 0);
    chk("rs busy async", busy, 0);
    req = 4'b0110; wen_in = '0;
    #2 resetn = 1'b1;
    tick();
    chk("rs ptr0 grant", grant, 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
